// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: request/result bundle between the client engines and
// the shared multiplier.
//   req_valid  [NUM_REQ]        per-requester operand valid
//   req_ready  [NUM_REQ]        per-requester accept, one-hot or zero
//   req_a      [NUM_REQ*WIDTH]  flattened operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      [NUM_REQ*WIDTH]  flattened operand B, same packing
//   res_valid                   product valid
//   res_ready                   consumer accepts the product
//   res_p      [WIDTH]          product, (a*b) mod 2^WIDTH
//   res_id     [ID_W]           index of the requester owning res_p
// Modports: master = client/consumer side, slave = arbiter side.
interface mult_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_p;
    logic [ID_W-1:0]          res_id;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        input  req_ready,
        input  res_valid,
        input  res_p,
        input  res_id,
        output res_ready
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        output req_ready,
        output res_valid,
        output res_p,
        output res_id,
        input  res_ready
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin scheduler time-sharing one registered
// WIDTH x WIDTH multiply stage among NUM_REQ requesters. One operand pair is
// accepted per cycle; the truncated product is registered together with the
// owning requester index.
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   bus           mult_share_arbiter_if.slave (request and result handshakes)
//   stat_accepts  [32] accept counter      (only with MULT_SHARE_STATS_EN)
//   stat_stalls   [32] blocked-cycle count (only with MULT_SHARE_STATS_EN)
// Optional feature macro: MULT_SHARE_STATS_EN.
module mult_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mult_share_arbiter_if.slave bus
`ifdef MULT_SHARE_STATS_EN
    ,
    output logic [31:0]         stat_accepts,
    output logic [31:0]         stat_stalls
`endif
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic              res_valid_q;
    logic [WIDTH-1:0]  res_p_q;
    logic [ID_W-1:0]   res_id_q;
    logic [ID_W-1:0]   last_q;

    logic [WIDTH-1:0]  a_arr [NUM_REQ];
    logic [WIDTH-1:0]  b_arr [NUM_REQ];

    logic              slot_free;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   scan_idx;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH-1:0]  prod;
    logic              accept;
    logic [NUM_REQ-1:0] req_ready_d;

    // Unpack the flattened operand buses once so the scan can index by requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end

    assign slot_free = !res_valid_q || bus.res_ready;

    // Scan upward from last+1, wrapping; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        a_sel       = '0;
        b_sel       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(last_q) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
                a_sel       = a_arr[scan_idx];
                b_sel       = b_arr[scan_idx];
            end
        end
    end

    // rst_n gates the grant so req_ready stays zero throughout reset.
    assign accept = rst_n && slot_free && grant_found;

    // Product is taken in WIDTH-bit context, so overflow bits fall away.
    assign prod = a_sel * b_sel;

    always_comb begin
        req_ready_d = '0;
        if (accept) begin
            req_ready_d[grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready = req_ready_d;
    assign bus.res_valid = res_valid_q;
    assign bus.res_p     = res_p_q;
    assign bus.res_id    = res_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_p_q     <= '0;
            res_id_q    <= '0;
            last_q      <= ID_W'(NUM_REQ - 1);
        end else begin
            if (accept) begin
                // Covers the simultaneous drain+accept case: no bubble.
                res_valid_q <= 1'b1;
                res_p_q     <= prod;
                res_id_q    <= grant_idx;
                last_q      <= grant_idx;
            end else if (bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

`ifdef MULT_SHARE_STATS_EN
    logic [31:0] stat_accepts_q;
    logic [31:0] stat_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accepts_q <= '0;
            stat_stalls_q  <= '0;
        end else begin
            if (accept) begin
                stat_accepts_q <= stat_accepts_q + 32'd1;
            end else if (|bus.req_valid) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign stat_accepts = stat_accepts_q;
    assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed plus randomized bench for mult_share_arbiter
// with a behavioural reference model (pointer, result slot, counters).
module tb_mult_share_arbiter;
    localparam int NR = 4;
    localparam int W  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

`ifdef MULT_SHARE_STATS_EN
    logic [31:0] stat_accepts;
    logic [31:0] stat_stalls;
`endif

    mult_share_arbiter #(
        .NUM_REQ (NR),
        .WIDTH   (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave)
`ifdef MULT_SHARE_STATS_EN
        ,
        .stat_accepts (stat_accepts),
        .stat_stalls  (stat_stalls)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus state
    logic [NR-1:0] v;
    logic [W-1:0]  a_op [NR];
    logic [W-1:0]  b_op [NR];
    logic          rdy;

    // Reference model state
    bit m_valid;
    int m_p;
    int m_id;
    int m_last;
    int m_acc;
    int m_stall;
    int last_accept;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = v;
        bus.req_a     = {a_op[3], a_op[2], a_op[1], a_op[0]};
        bus.req_b     = {b_op[3], b_op[2], b_op[1], b_op[0]};
        bus.res_ready = rdy;
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= NR; k++) begin
            if (v[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] model_ready();
        int g;
        logic [NR-1:0] r;
        r = '0;
        g = model_grant();
        if (rst_n && (!m_valid || rdy) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid     = 1'b0;
        m_p         = 0;
        m_id        = 0;
        m_last      = NR - 1;
        m_acc       = 0;
        m_stall     = 0;
        last_accept = -1;
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic do_cycle(input string tag);
        int g;
        longint prod;
        drive();
        #3;
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(model_ready()));
        @(posedge clk);
        g = model_grant();
        if ((!m_valid || rdy) && g >= 0) begin
            prod        = longint'(a_op[g]) * longint'(b_op[g]);
            m_p         = int'(prod % 65536);
            m_id        = g;
            m_valid     = 1'b1;
            m_last      = g;
            m_acc++;
            last_accept = g;
        end else begin
            if (m_valid && rdy) m_valid = 1'b0;
            if (|v) m_stall++;
            last_accept = -1;
        end
        #1;
        chk({tag, ".valid"}, 32'(bus.res_valid), 32'(m_valid));
        chk({tag, ".p"},     32'(bus.res_p),     32'(m_p));
        chk({tag, ".id"},    32'(bus.res_id),    32'(m_id));
    endtask

    task automatic do_reset(input string tag);
        drive();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, ".rst_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, ".rst_ready"}, 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, ".rst_p"},  32'(bus.res_p),  32'd0);
        chk({tag, ".rst_id"}, 32'(bus.res_id), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        v   = '0;
        rdy = 1'b1;
        for (int i = 0; i < NR; i++) begin
            a_op[i] = '0;
            b_op[i] = '0;
        end
        model_reset();
        drive();
        @(posedge clk);
        #1;

        // Reset state with every requester asking
        v = 4'b1111;
        do_reset("reset");

        // Single requester
        v = 4'b0010;
        a_op[1] = 16'd3;
        b_op[1] = 16'd5;
        do_cycle("single");
        chk("single.p_const",  32'(bus.res_p),  32'd15);
        chk("single.id_const", 32'(bus.res_id), 32'd1);
        v = '0;
        do_cycle("single_drain");

        // Round-robin from reset: ids 0,1,2,3,0,1,2,3 with no gaps
        do_reset("rr");
        for (int i = 0; i < NR; i++) begin
            a_op[i] = W'($urandom);
            b_op[i] = W'($urandom);
        end
        v   = 4'b1111;
        rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_cycle("rr");
            chk("rr.id_seq", 32'(bus.res_id), 32'(i % NR));
        end

        // Truncation
        v = 4'b0001;
        a_op[0] = 16'hFFFF;
        b_op[0] = 16'hFFFF;
        do_cycle("trunc_ff");
        chk("trunc_ff.p_const", 32'(bus.res_p), 32'h0001);
        v = 4'b0100;
        a_op[2] = 16'h0100;
        b_op[2] = 16'h0100;
        do_cycle("trunc_100");
        chk("trunc_100.p_const", 32'(bus.res_p), 32'h0000);

        // Backpressure: result held, no grants, then resume after last (2 -> 0)
        v   = 4'b0101;
        rdy = 1'b0;
        a_op[0] = 16'd7;
        b_op[0] = 16'd9;
        a_op[2] = 16'd11;
        b_op[2] = 16'd13;
        for (int i = 0; i < 3; i++) begin
            do_cycle("bp_stall");
            chk("bp.held_id", 32'(bus.res_id), 32'd2);
        end
        rdy = 1'b1;
        do_cycle("bp_resume");
        chk("bp.resume_id", 32'(bus.res_id), 32'd0);
        chk("bp.resume_p",  32'(bus.res_p),  32'd63);

        // Reset mid-stream while res_valid is high; req0 then beats req3
        v = 4'b1001;
        a_op[3] = 16'd2;
        b_op[3] = 16'd2;
        do_reset("midrst");
        do_cycle("midrst_after");
        chk("midrst.id0", 32'(bus.res_id), 32'd0);

`ifdef MULT_SHARE_STATS_EN
        // 5 accepts then 2 blocked cycles
        do_reset("stats");
        v   = 4'b1111;
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) do_cycle("stats_acc");
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) do_cycle("stats_blk");
        chk("stats.accepts", stat_accepts, 32'd5);
        chk("stats.stalls",  stat_stalls,  32'd2);
`endif

        // Randomized traffic obeying the hold-until-accepted rule
        do_reset("rand");
        v = '0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] && ($urandom_range(0, 1) == 1)) begin
                    v[i]    = 1'b1;
                    a_op[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
                    b_op[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            do_cycle("rand");
            if (last_accept >= 0) v[last_accept] = 1'b0;
        end

`ifdef MULT_SHARE_STATS_EN
        chk("rand.accepts", stat_accepts, 32'(m_acc));
        chk("rand.stalls",  stat_stalls,  32'(m_stall));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
